// File: rtl/vecmac_seq.sv
// vecmac_seq: sequencer for an external 8x8-byte dot-product MAC.
// Accepts a job length, streams operand beats into the MAC and sums the
// returned partial dot products into an accumulator, then presents the result.
//
// Optional feature macro: VECMAC_SAT_EN
//   defined   -> accumulator saturates at 2^ACCW-1 and res_ovf is set (sticky
//                until the next accepted command)
//   undefined -> accumulator wraps modulo 2^ACCW and res_ovf is tied to 0
//
// Handshake semantics (cmd, s, res): a transfer happens on a rising clk edge
// where valid && ready are both 1. A producer holding valid keeps its payload
// stable until the transfer; ready may depend on state only, never on valid.
//
// ACCW is expected to be at least 19 so a single MAC result fits.

module vecmac_seq #(
    parameter int BUSW    = 64,
    parameter int LATENCY = 8,
    parameter int ACCW    = 32,
    parameter int LENW    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    // job request
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [LENW-1:0]               cmd_len,
    // operand beats
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [BUSW-1:0]               s_a,
    input  logic [BUSW-1:0]               s_b,
    // MAC issue side
    output logic                          mac_in_valid,
    output logic [BUSW-1:0]               mac_in_a,
    output logic [BUSW-1:0]               mac_in_b,
    // MAC return side
    input  logic                          mac_out_valid,
    input  logic [18:0]                   mac_out_sum,
    // result
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [ACCW-1:0]               res_data,
    output logic                          res_ovf,
    // status / debug
    output logic                          busy,
    output logic [1:0]                    dbg_state,
    output logic [$clog2(LATENCY+2)-1:0]  dbg_inflight
);

    localparam int INF_W = $clog2(LATENCY + 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LENW-1:0]   issue_cnt;
    logic [LENW-1:0]   ret_cnt;
    logic [ACCW-1:0]   acc;
    logic [ACCW-1:0]   acc_next;
    logic [INF_W-1:0]  inflight;

    logic              cmd_fire;
    logic              beat_fire;
    logic              ret_fire;
    logic              res_fire;

    // Handshake qualifiers; MAC returns only count while a job is collecting.
    always_comb begin
        cmd_fire  = cmd_valid && (state == ST_IDLE);
        beat_fire = s_valid && (state == ST_ISSUE);
        ret_fire  = mac_out_valid && ((state == ST_ISSUE) || (state == ST_DRAIN));
        res_fire  = res_ready && (state == ST_DONE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        s_ready   = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_fire) begin
                    state_nxt = (cmd_len == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                s_ready = 1'b1;
                if (ret_fire && (ret_cnt == LENW'(1))) begin
                    state_nxt = ST_DONE;
                end else if (beat_fire && (issue_cnt == LENW'(1))) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (ret_fire && (ret_cnt == LENW'(1))) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_fire) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef VECMAC_SAT_EN
    logic [ACCW:0] acc_sum;
    logic          ovf_hit;
    logic          ovf_q;

    // Saturating accumulate: a carry out of ACCW bits clamps to all ones.
    always_comb begin
        acc_sum  = {1'b0, acc} + (ACCW+1)'(mac_out_sum);
        ovf_hit  = acc_sum[ACCW];
        acc_next = ovf_hit ? {ACCW{1'b1}} : acc_sum[ACCW-1:0];
    end

    // Sticky overflow flag, cleared only when a new job is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (cmd_fire) begin
            ovf_q <= 1'b0;
        end else if (ret_fire && ovf_hit) begin
            ovf_q <= 1'b1;
        end
    end

    assign res_ovf = ovf_q;
`else
    // Wrapping accumulate modulo 2^ACCW.
    always_comb begin
        acc_next = acc + ACCW'(mac_out_sum);
    end

    assign res_ovf = 1'b0;
`endif

    // Job counters and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            ret_cnt   <= '0;
            acc       <= '0;
        end else if (cmd_fire) begin
            issue_cnt <= cmd_len;
            ret_cnt   <= cmd_len;
            acc       <= '0;
        end else begin
            if (beat_fire) begin
                issue_cnt <= issue_cnt - LENW'(1);
            end
            if (ret_fire) begin
                ret_cnt <= ret_cnt - LENW'(1);
                acc     <= acc_next;
            end
        end
    end

    // MAC operand registers: one-cycle valid pulse per accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_in_valid <= 1'b0;
            mac_in_a     <= '0;
            mac_in_b     <= '0;
        end else begin
            mac_in_valid <= beat_fire;
            if (beat_fire) begin
                mac_in_a <= s_a;
                mac_in_b <= s_b;
            end
        end
    end

    // Count of beats issued to the MAC whose results have not yet returned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (cmd_fire) begin
            inflight <= '0;
        end else begin
            case ({mac_in_valid, ret_fire})
                2'b10:   inflight <= inflight + INF_W'(1);
                2'b01:   inflight <= inflight - INF_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    assign res_data     = acc;
    assign dbg_state    = state;
    assign dbg_inflight = inflight;

endmodule

// File: tb/tb_vecmac_seq.sv
// tb_vecmac_seq: directed bench for vecmac_seq. Two instances share inputs:
// dut_a uses default ACCW=32, dut_b uses ACCW=20 for the overflow case.
// A behavioural LATENCY-stage dot-product MAC sits between them and the bench.

module tb_vecmac_seq;

    localparam int LAT = 8;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared stimulus ----------------
    logic        cmd_valid;
    logic [15:0] cmd_len;
    logic        s_valid;
    logic [63:0] s_a;
    logic [63:0] s_b;
    logic        res_ready;

    logic        mac_out_valid;
    logic [18:0] mac_out_sum;

    // ---------------- DUT A (ACCW=32) ----------------
    logic        a_cmd_ready, a_s_ready, a_mac_in_valid, a_res_valid, a_res_ovf, a_busy;
    logic [63:0] a_mac_in_a, a_mac_in_b;
    logic [31:0] a_res_data;
    logic [1:0]  a_dbg_state;
    logic [3:0]  a_dbg_inflight;

    vecmac_seq #(.BUSW(64), .LATENCY(LAT), .ACCW(32), .LENW(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready), .cmd_len(cmd_len),
        .s_valid(s_valid), .s_ready(a_s_ready), .s_a(s_a), .s_b(s_b),
        .mac_in_valid(a_mac_in_valid), .mac_in_a(a_mac_in_a), .mac_in_b(a_mac_in_b),
        .mac_out_valid(mac_out_valid), .mac_out_sum(mac_out_sum),
        .res_valid(a_res_valid), .res_ready(res_ready), .res_data(a_res_data),
        .res_ovf(a_res_ovf), .busy(a_busy),
        .dbg_state(a_dbg_state), .dbg_inflight(a_dbg_inflight)
    );

    // ---------------- DUT B (ACCW=20) ----------------
    logic        b_cmd_ready, b_s_ready, b_mac_in_valid, b_res_valid, b_res_ovf, b_busy;
    logic [63:0] b_mac_in_a, b_mac_in_b;
    logic [19:0] b_res_data;
    logic [1:0]  b_dbg_state;
    logic [3:0]  b_dbg_inflight;

    vecmac_seq #(.BUSW(64), .LATENCY(LAT), .ACCW(20), .LENW(16)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready), .cmd_len(cmd_len),
        .s_valid(s_valid), .s_ready(b_s_ready), .s_a(s_a), .s_b(s_b),
        .mac_in_valid(b_mac_in_valid), .mac_in_a(b_mac_in_a), .mac_in_b(b_mac_in_b),
        .mac_out_valid(mac_out_valid), .mac_out_sum(mac_out_sum),
        .res_valid(b_res_valid), .res_ready(res_ready), .res_data(b_res_data),
        .res_ovf(b_res_ovf), .busy(b_busy),
        .dbg_state(b_dbg_state), .dbg_inflight(b_dbg_inflight)
    );

    // ---------------- behavioural MAC ----------------
    function automatic logic [18:0] dot8(input logic [63:0] a, input logic [63:0] b);
        logic [18:0] s;
        s = '0;
        for (int k = 0; k < 8; k++) begin
            s = s + 19'(a[k*8 +: 8] * b[k*8 +: 8]);
        end
        return s;
    endfunction

    logic [LAT-1:0] mac_pv;
    logic [18:0]    mac_ps [LAT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_pv <= '0;
            for (int i = 0; i < LAT; i++) mac_ps[i] <= '0;
        end else begin
            mac_pv    <= {mac_pv[LAT-2:0], a_mac_in_valid};
            mac_ps[0] <= dot8(a_mac_in_a, a_mac_in_b);
            for (int i = 1; i < LAT; i++) mac_ps[i] <= mac_ps[i-1];
        end
    end

    assign mac_out_valid = mac_pv[LAT-1];
    assign mac_out_sum   = mac_ps[LAT-1];

    // Count of cycles with mac_in_valid high (sampled at the edge).
    int mac_in_cnt;
    initial mac_in_cnt = 0;
    always @(posedge clk) if (a_mac_in_valid) mac_in_cnt <= mac_in_cnt + 1;

    // ---------------- scoreboard / checking ----------------
    int checks;
    int failures;
    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [15:0] len);
        chk("cmd_ready_idle", 64'(a_cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res(input string tag, output int cyc);
        cyc = 0;
        while (!a_res_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        chk({tag, "_res_timeout"}, 64'(a_res_valid), 64'd1);
    endtask

    task automatic ack_res();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("ack_res_valid_low", 64'(a_res_valid), 64'd0);
        chk("ack_cmd_ready", 64'(a_cmd_ready), 64'd1);
    endtask

    // ---------------- directed sequence ----------------
    int   cyc;
    int   base;
    logic seen;

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        s_valid   = 1'b0;
        s_a       = '0;
        s_b       = '0;
        res_ready = 1'b0;

        // reset values
        tick(); tick(); tick();
        chk("rst_cmd_ready", 64'(a_cmd_ready), 64'd1);
        chk("rst_s_ready", 64'(a_s_ready), 64'd0);
        chk("rst_mac_in_valid", 64'(a_mac_in_valid), 64'd0);
        chk("rst_mac_in_a", a_mac_in_a, 64'd0);
        chk("rst_res_valid", 64'(a_res_valid), 64'd0);
        chk("rst_res_ovf", 64'(a_res_ovf), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_res_data", 64'(a_res_data), 64'd0);
        chk("rst_state", 64'(a_dbg_state), 64'd0);
        rst_n = 1'b1;
        tick();

        // len=1, all 0xFF: latency and value
        send_cmd(16'd1);
        chk("t1_busy", 64'(a_busy), 64'd1);
        chk("t1_s_ready", 64'(a_s_ready), 64'd1);
        s_valid = 1'b1;
        s_a     = '1;
        s_b     = '1;
        tick();
        s_valid = 1'b0;
        chk("t1_mac_in_valid", 64'(a_mac_in_valid), 64'd1);
        chk("t1_mac_in_a", a_mac_in_a, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t1_s_ready_drain", 64'(a_s_ready), 64'd0);
        tick();
        chk("t1_mac_in_pulse", 64'(a_mac_in_valid), 64'd0);
        wait_res("t1", cyc);
        chk("t1_latency", 64'(cyc + 1), 64'(LAT + 1));
        exp_q.push_back(64'd520200);
        chk("t1_res_data", 64'(a_res_data), exp_q.pop_front());
        chk("t1_res_ovf", 64'(a_res_ovf), 64'd0);
        chk("t1_b_res_data", 64'(b_res_data), 64'd520200);
        ack_res();

        // len=4 back-to-back, s_valid held high
        base = mac_in_cnt;
        send_cmd(16'd4);
        s_valid = 1'b1;
        s_a     = '1;
        s_b     = '1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_s_ready_stream", 64'(a_s_ready), 64'd1);
            tick();
            chk("t2_mac_in_valid", 64'(a_mac_in_valid), 64'd1);
        end
        chk("t2_s_ready_after", 64'(a_s_ready), 64'd0);
        s_valid = 1'b0;
        tick();
        chk("t2_mac_in_valid_end", 64'(a_mac_in_valid), 64'd0);
        chk("t2_mac_in_count", 64'(mac_in_cnt - base), 64'd4);
        wait_res("t2", cyc);
        chk("t2_res_data", 64'(a_res_data), 64'd2080800);
`ifdef VECMAC_SAT_EN
        chk("t2_b_res_data", 64'(b_res_data), 64'd1048575);
        chk("t2_b_res_ovf", 64'(b_res_ovf), 64'd1);
`else
        chk("t2_b_res_data", 64'(b_res_data), 64'd1032224);
        chk("t2_b_res_ovf", 64'(b_res_ovf), 64'd0);
`endif

        // res_ready held low: result held, no new command
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_res_valid", 64'(a_res_valid), 64'd1);
            chk("t3_hold_res_data", 64'(a_res_data), 64'd2080800);
            chk("t3_hold_cmd_ready", 64'(a_cmd_ready), 64'd0);
        end

        // handshake with cmd_valid already up: accepted one cycle later; len=0
        base      = mac_in_cnt;
        res_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_len   = 16'd0;
        tick();
        res_ready = 1'b0;
        chk("t3_res_valid_dropped", 64'(a_res_valid), 64'd0);
        chk("t3_cmd_ready_idle", 64'(a_cmd_ready), 64'd1);
        chk("t3_busy_idle", 64'(a_busy), 64'd0);
        tick();
        cmd_valid = 1'b0;
        chk("t4_len0_res_valid", 64'(a_res_valid), 64'd1);
        chk("t4_len0_res_data", 64'(a_res_data), 64'd0);
        chk("t4_len0_cmd_ready", 64'(a_cmd_ready), 64'd0);
        ack_res();
        chk("t4_len0_no_mac_in", 64'(mac_in_cnt - base), 64'd0);

        // ACCW=20, len=3, all 0xFF
        send_cmd(16'd3);
        s_valid = 1'b1;
        s_a     = '1;
        s_b     = '1;
        tick(); tick(); tick();
        s_valid = 1'b0;
        wait_res("t5", cyc);
        chk("t5_a_res_data", 64'(a_res_data), 64'd1560600);
`ifdef VECMAC_SAT_EN
        chk("t5_b_res_data", 64'(b_res_data), 64'd1048575);
        chk("t5_b_res_ovf", 64'(b_res_ovf), 64'd1);
`else
        chk("t5_b_res_data", 64'(b_res_data), 64'd512024);
        chk("t5_b_res_ovf", 64'(b_res_ovf), 64'd0);
`endif
        ack_res();

        // reset pulsed during DRAIN of a len=4 job
        send_cmd(16'd4);
        s_valid = 1'b1;
        tick(); tick(); tick(); tick();
        s_valid = 1'b0;
        tick(); tick();
        chk("t6_in_drain", 64'(a_dbg_state), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 64'(a_busy), 64'd0);
        chk("t6_rst_res_valid", 64'(a_res_valid), 64'd0);
        chk("t6_rst_s_ready", 64'(a_s_ready), 64'd0);
        chk("t6_rst_mac_in_valid", 64'(a_mac_in_valid), 64'd0);
        chk("t6_rst_mac_in_a", a_mac_in_a, 64'd0);
        chk("t6_rst_res_data", 64'(a_res_data), 64'd0);
        chk("t6_rst_cmd_ready", 64'(a_cmd_ready), 64'd1);
        tick(); tick();
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen = seen | a_res_valid | b_res_valid;
        end
        chk("t6_no_partial_result", 64'(seen), 64'd0);

        // follow-up len=1 job, all bytes 0x01
        send_cmd(16'd1);
        s_valid = 1'b1;
        s_a     = 64'h0101_0101_0101_0101;
        s_b     = 64'h0101_0101_0101_0101;
        tick();
        s_valid = 1'b0;
        wait_res("t7", cyc);
        chk("t7_res_data", 64'(a_res_data), 64'd8);
        chk("t7_b_res_data", 64'(b_res_data), 64'd8);
        ack_res();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
